// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: write-only SPI-slave (mode 0) deframer feeding an 8-bit config register bank.
// Optional feature macro SPI_CFG_PARITY_EN: 17-bit frames carrying a trailing odd-parity bit.
module spi_cfg_sync #(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) ff <= {SYNC{RST_VAL}};
    else      ff <= {ff[SYNC-2:0], d};
  end

  assign q = ff[SYNC-1];
endmodule

module spi_cfg_ctrl #(
  parameter int                 NREGS   = 8,
  parameter int                 SYNC    = 2,
  parameter logic [8*NREGS-1:0] CFG_RST = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_nss,
  input  logic               cfg_lock,
  output logic [8*NREGS-1:0] cfg,
  output logic               cfg_wr_stb,
  output logic [7:0]         cfg_wr_addr,
  output logic               busy,
  output logic [2:0]         err
);
`ifdef SPI_CFG_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam int            NL       = 3;
  localparam logic [NL-1:0] LINE_RST = 3'b100;  // {nss, mosi, sclk}: nss idles high

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [NL-1:0] pin, ln_s;
  logic          sclk_s, mosi_s, nss_s, sclk_d, nss_d;
  logic          sclk_rise, nss_fall, nss_rise, frame_start;
  state_t        state, state_nx;
  logic [4:0]    cnt;
  logic [FW-1:0] sh;
  logic [7:0]    f_addr, f_data;
  logic          shift_en, len_bad, par_bad, addr_bad, chk_ok;
  logic          pend_v, pend_ld, pend_clr, ovf, wr_en;
  logic [7:0]    pend_addr, pend_data, wr_addr, wr_data;

  assign pin = {spi_nss, spi_mosi, spi_clk};

  for (genvar g = 0; g < NL; g++) begin : g_sync
    spi_cfg_sync #(.SYNC(SYNC), .RST_VAL(LINE_RST[g])) u_sync (
      .clk(clk), .rst(rst), .d(pin[g]), .q(ln_s[g])
    );
  end

  assign {nss_s, mosi_s, sclk_s} = ln_s;
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign nss_fall    = nss_d & ~nss_s;
  assign nss_rise    = nss_s & ~nss_d;
  assign frame_start = (state != SHIFT) && nss_fall;
  assign f_addr      = sh[FW-1 -: 8];
  assign f_data      = sh[FW-9 -: 8];
  assign busy        = ~nss_s | pend_v;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // A select edge arriving during CHECK still starts a frame; the commit is not lost.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (nss_fall) state_nx = SHIFT;
      SHIFT:   if (nss_rise) state_nx = CHECK;
      CHECK:   state_nx = nss_fall ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    len_bad  = 1'b0;
    par_bad  = 1'b0;
    addr_bad = 1'b0;
    chk_ok   = 1'b0;
    if (state == SHIFT) shift_en = sclk_rise;
    if (state == CHECK) begin
      len_bad  = (cnt != 5'(FW));
`ifdef SPI_CFG_PARITY_EN
      par_bad  = !len_bad && !(^sh);
`endif
      addr_bad = !len_bad && !par_bad && ({1'b0, f_addr} >= 9'(NREGS));
      chk_ok   = !len_bad && !par_bad && !addr_bad;
    end
  end

  // One bank write per cycle; a releasable pending frame always goes first.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = pend_addr;
    wr_data  = pend_data;
    pend_ld  = 1'b0;
    pend_clr = 1'b0;
    ovf      = 1'b0;
    if (pend_v && !cfg_lock) begin
      wr_en    = 1'b1;
      pend_ld  = chk_ok;
      pend_clr = !chk_ok;
    end else if (chk_ok) begin
      if (!cfg_lock) begin
        wr_en   = 1'b1;
        wr_addr = f_addr;
        wr_data = f_data;
      end else if (!pend_v) pend_ld = 1'b1;
      else                  ovf     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_d      <= 1'b0;
      nss_d       <= 1'b1;
      cnt         <= '0;
      sh          <= '0;
      cfg         <= CFG_RST;
      cfg_wr_stb  <= 1'b0;
      cfg_wr_addr <= '0;
      err         <= '0;
      pend_v      <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
    end else begin
      sclk_d     <= sclk_s;
      nss_d      <= nss_s;
      cfg_wr_stb <= 1'b0;
      if (frame_start) begin
        cnt <= '0;
        sh  <= '0;
      end else if (shift_en) begin
        sh <= {sh[FW-2:0], mosi_s};
        if (cnt != 5'd31) cnt <= cnt + 5'd1;
      end
      if (len_bad || par_bad) err[0] <= 1'b1;
      if (addr_bad)           err[1] <= 1'b1;
      if (ovf)                err[2] <= 1'b1;
      if (pend_ld) begin
        pend_v    <= 1'b1;
        pend_addr <= f_addr;
        pend_data <= f_data;
      end else if (pend_clr) pend_v <= 1'b0;
      if (wr_en) begin
        cfg_wr_stb  <= 1'b1;
        cfg_wr_addr <= wr_addr;
        for (int i = 0; i < NREGS; i++)
          if (wr_addr == 8'(i)) cfg[8*i +: 8] <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Bench for spi_cfg_ctrl: expected bank writes are queued as frames are sent and popped on each strobe.
module tb_spi_cfg_ctrl;
  localparam int          NREGS   = 8;
  localparam int          SYNC    = 2;
  localparam logic [63:0] CFG_RST = 64'h0807060504030201;
`ifdef SPI_CFG_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif

  logic        clk = 0, rst = 0, spi_clk = 0, spi_mosi = 0, spi_nss = 1, cfg_lock = 0;
  logic [63:0] cfg;
  logic        cfg_wr_stb, busy;
  logic [7:0]  cfg_wr_addr;
  logic [2:0]  err;

  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [63:0] exp_cfg;
  int          checks = 0, failures = 0, stb_cnt = 0;

  spi_cfg_ctrl #(.NREGS(NREGS), .SYNC(SYNC), .CFG_RST(CFG_RST)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_nss(spi_nss),
    .cfg_lock(cfg_lock), .cfg(cfg), .cfg_wr_stb(cfg_wr_stb), .cfg_wr_addr(cfg_wr_addr),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cfg_wr_stb === 1'b1) stb_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] d);
`ifdef SPI_CFG_PARITY_EN
    return {15'd0, a, d, ~^{a, d}};
`else
    return {16'd0, a, d};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    spi_nss = 0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      tick(4);
      spi_clk = 1;
      tick(4);
      spi_clk = 0;
    end
    tick(4);
    spi_nss = 1;
  endtask

  task automatic wait_stb(input int max, output bit got);
    got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cfg_wr_stb === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 0;
    cfg_lock = 0;
    spi_nss = 1;
    spi_clk = 0;
    tick(2);
    rst = 1;
    exp_cfg = CFG_RST;
    exp_q.delete();
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cfg !== CFG_RST) begin failures++; $display("FAIL reset_cfg: got %h want %h", cfg, CFG_RST); end
    checks++; if (err !== 3'b000) begin failures++; $display("FAIL reset_err: got %b want 000", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cfg_wr_stb !== 1'b0 || cfg_wr_addr !== 8'h00) begin
      failures++; $display("FAIL reset_stb: stb %b addr %h want 0/00", cfg_wr_stb, cfg_wr_addr); end
  endtask

  task automatic test_write();
    int s0; bit got; wr_t e;
    s0 = stb_cnt;
    exp_q.push_back('{8'h03, 8'h55});
    send_bits(mk_frame(8'h03, 8'h55), FW);
    wait_stb(SYNC + 3, got);
    checks++;
    if (!got) begin failures++; $display("FAIL write_latency: no strobe within %0d clk", SYNC + 3); end
    else begin
      e = exp_q.pop_front();
      exp_cfg[8*e.a +: 8] = e.d;
      checks++; if (cfg_wr_addr !== e.a) begin failures++; $display("FAIL write_addr: got %h want %h", cfg_wr_addr, e.a); end
      checks++; if (cfg[31:24] !== 8'h55) begin failures++; $display("FAIL write_data: got %h want 55", cfg[31:24]); end
    end
    tick(8);
    checks++; if (stb_cnt !== s0 + 1) begin failures++; $display("FAIL write_stb_count: got %0d want %0d", stb_cnt - s0, 1); end
    checks++; if (cfg !== exp_cfg) begin failures++; $display("FAIL write_bank: got %h want %h", cfg, exp_cfg); end
  endtask

  task automatic test_length();
    int s0;
    do_reset();
    s0 = stb_cnt;
    send_bits(32'h0000_5355, FW - 1);
    tick(10);
    checks++; if (err !== 3'b001) begin failures++; $display("FAIL len_short_err: got %b want 001", err); end
    do_reset();
    send_bits(32'h0002_0355, FW + 2);
    tick(10);
    checks++; if (err !== 3'b001) begin failures++; $display("FAIL len_long_err: got %b want 001", err); end
    checks++; if (stb_cnt !== s0) begin failures++; $display("FAIL len_no_stb: got %0d strobes want 0", stb_cnt - s0); end
    checks++; if (cfg !== exp_cfg) begin failures++; $display("FAIL len_bank: got %h want %h", cfg, exp_cfg); end
  endtask

  task automatic test_bad_addr();
    int s0;
    do_reset();
    s0 = stb_cnt;
    send_bits(mk_frame(8'h0A, 8'hFF), FW);
    tick(10);
    checks++; if (err !== 3'b010) begin failures++; $display("FAIL addr_err: got %b want 010", err); end
    checks++; if (stb_cnt !== s0) begin failures++; $display("FAIL addr_no_stb: got %0d strobes want 0", stb_cnt - s0); end
    checks++; if (cfg !== exp_cfg) begin failures++; $display("FAIL addr_bank: got %h want %h", cfg, exp_cfg); end
  endtask

  task automatic test_back_to_back();
    bit got; wr_t e; logic [7:0] a, d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? 8'd0 : (k == 1) ? 8'd7 : 8'($urandom_range(0, NREGS - 1));
      d = 8'($urandom);
      exp_q.push_back('{a, d});
      send_bits(mk_frame(a, d), FW);
      wait_stb(SYNC + 3, got);
      checks++;
      if (!got) begin failures++; $display("FAIL b2b_timeout: frame %0d no strobe", k); end
      else begin
        e = exp_q.pop_front();
        exp_cfg[8*e.a +: 8] = e.d;
        checks++; if (cfg_wr_addr !== e.a || cfg[8*e.a +: 8] !== e.d) begin
          failures++; $display("FAIL b2b_write: frame %0d got %h:%h want %h:%h", k, cfg_wr_addr, cfg[8*e.a +: 8], e.a, e.d); end
      end
    end
    tick(4);
    checks++; if (cfg !== exp_cfg) begin failures++; $display("FAIL b2b_bank: got %h want %h", cfg, exp_cfg); end
  endtask

  task automatic test_lock();
    int s0; bit got; wr_t e;
    do_reset();
    s0 = stb_cnt;
    cfg_lock = 1;
    exp_q.push_back('{8'h01, 8'hAA});
    send_bits(mk_frame(8'h01, 8'hAA), FW);
    tick(12);
    checks++; if (stb_cnt !== s0) begin failures++; $display("FAIL lock_hold: got %0d strobes want 0", stb_cnt - s0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lock_busy: got %b want 1", busy); end
    cfg_lock = 0;
    wait_stb(3, got);
    checks++;
    if (!got) begin failures++; $display("FAIL lock_release: no strobe after unlock"); end
    else begin
      e = exp_q.pop_front();
      exp_cfg[8*e.a +: 8] = e.d;
      checks++; if (cfg_wr_addr !== e.a || cfg[15:8] !== 8'hAA) begin
        failures++; $display("FAIL lock_apply: got %h:%h want %h:aa", cfg_wr_addr, cfg[15:8], e.a); end
    end
    tick(4);
    cfg_lock = 1;
    s0 = stb_cnt;
    exp_q.push_back('{8'h01, 8'h11});
    send_bits(mk_frame(8'h01, 8'h11), FW);
    tick(8);
    send_bits(mk_frame(8'h01, 8'h22), FW);
    tick(12);
    checks++; if (err !== 3'b100) begin failures++; $display("FAIL lock_ovf_err: got %b want 100", err); end
    checks++; if (stb_cnt !== s0) begin failures++; $display("FAIL lock_ovf_hold: got %0d strobes want 0", stb_cnt - s0); end
    cfg_lock = 0;
    wait_stb(3, got);
    checks++;
    if (!got) begin failures++; $display("FAIL lock_ovf_release: no strobe after unlock"); end
    else begin
      e = exp_q.pop_front();
      exp_cfg[8*e.a +: 8] = e.d;
      checks++; if (cfg[15:8] !== 8'h11) begin failures++; $display("FAIL lock_ovf_kept: got %h want 11", cfg[15:8]); end
    end
    tick(10);
    checks++; if (stb_cnt !== s0 + 1) begin failures++; $display("FAIL lock_ovf_count: got %0d strobes want 1", stb_cnt - s0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lock_idle_busy: got %b want 0", busy); end
    checks++; if (cfg !== exp_cfg) begin failures++; $display("FAIL lock_bank: got %h want %h", cfg, exp_cfg); end
  endtask

`ifdef SPI_CFG_PARITY_EN
  task automatic test_parity();
    int s0; bit got; wr_t e; logic [31:0] f;
    do_reset();
    s0 = stb_cnt;
    f = mk_frame(8'h02, 8'h33);
    f[0] = ~f[0];
    send_bits(f, FW);
    tick(10);
    checks++; if (err !== 3'b001) begin failures++; $display("FAIL parity_err: got %b want 001", err); end
    checks++; if (stb_cnt !== s0) begin failures++; $display("FAIL parity_no_stb: got %0d strobes want 0", stb_cnt - s0); end
    do_reset();
    exp_q.push_back('{8'h02, 8'h33});
    send_bits(mk_frame(8'h02, 8'h33), FW);
    wait_stb(SYNC + 3, got);
    checks++;
    if (!got) begin failures++; $display("FAIL parity_ok_timeout: no strobe"); end
    else begin
      e = exp_q.pop_front();
      exp_cfg[8*e.a +: 8] = e.d;
      checks++; if (cfg[23:16] !== 8'h33) begin failures++; $display("FAIL parity_ok_data: got %h want 33", cfg[23:16]); end
    end
    checks++; if (err !== 3'b000) begin failures++; $display("FAIL parity_ok_err: got %b want 000", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_length();
    test_bad_addr();
    test_back_to_back();
    test_lock();
`ifdef SPI_CFG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
